// File: rtl/bus_router_rr.sv
// Shared-bus router: round-robin arbitration among N source FIFOs, one packet
// per three cycles, with unicast/broadcast delivery and saturating statistics.
module bus_router_rr #(
   parameter int                 WIDTH     = 16,
   parameter int                 DEVICES   = 4,
   parameter int                 ID_BITS   = 8,
   parameter logic [ID_BITS-1:0] BROADCAST = 8'hFF,
   parameter int                 CNT_W     = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [DEVICES-1:0]       pndng,
   input  logic [DEVICES*WIDTH-1:0] D_pop,
   output logic [DEVICES-1:0]       pop,
   output logic [DEVICES-1:0]       push,
   output logic [DEVICES*WIDTH-1:0] D_push,
   output logic                     busy,
   output logic [CNT_W-1:0]         pkt_cnt,
   output logic [CNT_W-1:0]         drop_cnt
);

   localparam int GW = $clog2(DEVICES);

   typedef enum logic [1:0] {IDLE, POP, ROUTE} state_t;

   state_t             state, state_nxt;
   logic [GW-1:0]      grant, last_grant, grant_nxt, cand;
   logic [WIDTH-1:0]   data_q;
   logic [WIDTH-1:0]   src [DEVICES];
   logic [ID_BITS-1:0] dest;
   logic               found, deliver, drop;

   always_comb begin
      for (int unsigned i = 0; i < DEVICES; i++) begin
         src[i] = D_pop[i*WIDTH +: WIDTH];
      end
   end

   // First pending device after last_grant, wrapping; the oldest loser wins.
   always_comb begin
      found     = 1'b0;
      grant_nxt = last_grant;
      cand      = '0;
      for (int unsigned k = 1; k <= DEVICES; k++) begin
         cand = GW'((32'(last_grant) + k) % DEVICES);
         if (!found && pndng[cand]) begin
            found     = 1'b1;
            grant_nxt = cand;
         end
      end
   end

   assign dest = data_q[WIDTH-1 -: ID_BITS];

   always_comb begin
      state_nxt = state;
      pop       = '0;
      push      = '0;
      deliver   = 1'b0;
      drop      = 1'b0;
      case (state)
         IDLE: begin
            if (found) state_nxt = POP;
         end
         POP: begin
            pop[grant] = 1'b1;
            state_nxt  = ROUTE;
         end
         ROUTE: begin
            state_nxt = IDLE;
            if (dest == BROADCAST) begin
               deliver = 1'b1;
               for (int unsigned i = 0; i < DEVICES; i++) begin
                  push[i] = (GW'(i) != grant);
               end
            end else if (32'(dest) < 32'(DEVICES) && GW'(dest) != grant) begin
               deliver           = 1'b1;
               push[GW'(dest)]   = 1'b1;
            end else begin
               drop = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         grant      <= '0;
         last_grant <= GW'(DEVICES - 1);
         data_q     <= '0;
         pkt_cnt    <= '0;
         drop_cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && found) grant <= grant_nxt;
         if (state == POP) begin
            data_q     <= src[grant];
            last_grant <= grant;
         end
         if (deliver && pkt_cnt != '1)  pkt_cnt  <= pkt_cnt + CNT_W'(1);
         if (drop && drop_cnt != '1)    drop_cnt <= drop_cnt + CNT_W'(1);
      end
   end

   // data_q only changes at the end of POP, so it already holds the last routed word.
   assign D_push = {DEVICES{data_q}};
   assign busy   = (state != IDLE);

endmodule

// File: tb/tb_bus_router_rr.sv
// Scoreboard bench for bus_router_rr: source FIFOs modelled as queues, expected
// pushes queued at pop time and compared on the following cycle.
module tb_bus_router_rr;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  pndng;
   logic [63:0] D_pop;
   logic [3:0]  pop, push, pop_s, push_s;
   logic [63:0] D_push, D_push_s;
   logic        busy, busy_s;
   logic [15:0] pkt_cnt, drop_cnt;
   logic [3:0]  pkt_s, drop_s;

   bus_router_rr dut (
      .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .pop(pop),
      .push(push), .D_push(D_push), .busy(busy), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
   );

   bus_router_rr #(.CNT_W(4)) dut_sat (
      .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .pop(pop_s),
      .push(push_s), .D_push(D_push_s), .busy(busy_s), .pkt_cnt(pkt_s), .drop_cnt(drop_s)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  mask;
      logic [15:0] data;
      logic        deliver;
   } exp_t;

   logic [15:0] fifo [4][$];
   exp_t        push_q [$];
   int          pop_order [$];
   int          pop_cycles [$];
   int          checks = 0, errors = 0, cyc = 0;
   int          exp_grant = 0, last_exp = 3, deferred = -1;
   bit          pop_due = 1'b0;
   int unsigned exp_pkt = 0, exp_pkt_s = 0, exp_drop = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int rr(input int last, input logic [3:0] p);
      for (int k = 1; k <= 4; k++) begin
         int j;
         j = (last + k) % 4;
         if (p[j]) return j;
      end
      return 0;
   endfunction

   function automatic exp_t decode(input logic [15:0] w, input int g);
      exp_t       e;
      logic [7:0] d;
      d         = w[15:8];
      e.data    = w;
      e.mask    = 4'b0000;
      e.deliver = 1'b0;
      if (d == 8'hFF) begin
         e.mask    = 4'hF;
         e.mask[g] = 1'b0;
         e.deliver = 1'b1;
      end else if (d < 8'd4 && int'(d) != g) begin
         e.mask[d[1:0]] = 1'b1;
         e.deliver      = 1'b1;
      end
      return e;
   endfunction

   function automatic int idx_of(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic bit all_empty();
      for (int i = 0; i < 4; i++) if (fifo[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   // One clock: drive inputs at a negedge, predict, then sample at the next negedge.
   task automatic step();
      exp_t       e;
      logic [3:0] em;
      logic       rst_pending;
      for (int i = 0; i < 4; i++) begin
         pndng[i]        = (fifo[i].size() != 0);
         D_pop[i*16 +: 16] = (fifo[i].size() != 0) ? fifo[i][0] : 16'h0000;
      end
      rst_pending = reset;
      if (!reset && busy === 1'b0 && pndng != 4'b0000) begin
         exp_grant = rr(last_exp, pndng);
         pop_due   = 1'b1;
      end
      @(negedge clk);
      cyc++;
      if (rst_pending) begin
         push_q.delete();
         pop_due   = 1'b0;
         last_exp  = 3;
         exp_pkt   = 0;
         exp_pkt_s = 0;
         exp_drop  = 0;
      end
      if (deferred >= 0) begin
         void'(fifo[deferred].pop_front());
         deferred = -1;
      end
      if (push_q.size() != 0) begin
         e = push_q.pop_front();
         check("push_mask", {60'd0, push}, {60'd0, e.mask});
         if (e.mask != 4'b0000) check("push_data", D_push, {4{e.data}});
         if (e.deliver) begin
            exp_pkt++;
            if (exp_pkt_s < 15) exp_pkt_s++;
         end else begin
            exp_drop++;
         end
      end else if (push != 4'b0000) begin
         check("push_spurious", {60'd0, push}, 64'd0);
      end
      if (pop_due) begin
         em = 4'b0001 << exp_grant;
         check("pop_grant", {60'd0, pop}, {60'd0, em});
         pop_order.push_back(idx_of(pop));
         pop_cycles.push_back(cyc);
         push_q.push_back(decode(fifo[exp_grant][0], exp_grant));
         deferred = exp_grant;
         last_exp = exp_grant;
         pop_due  = 1'b0;
      end else if (pop != 4'b0000) begin
         check("pop_spurious", {60'd0, pop}, 64'd0);
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (n < 300 && !(all_empty() && push_q.size() == 0 && !pop_due &&
                          deferred < 0 && busy === 1'b0)) begin
         step();
         n++;
      end
      if (n >= 300) check("idle_timeout", 64'd1, 64'd0);
      step();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      int          rr_exp [5];
      int unsigned pkt_before;
      int          n;
      rr_exp = '{0, 1, 2, 3, 0};
      reset  = 1'b1;
      pndng  = '0;
      D_pop  = '0;
      repeat (3) step();
      check("rst_pop",  {60'd0, pop}, 64'd0);
      check("rst_push", {60'd0, push}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_pkt",  {48'd0, pkt_cnt}, 64'd0);
      check("rst_drop", {48'd0, drop_cnt}, 64'd0);
      check("rst_dpush", D_push, 64'd0);
      reset = 1'b0;
      step();

      // Round-robin with every device pending; device 0 has a second packet.
      fifo[0].push_back(16'h0110);
      fifo[1].push_back(16'h0221);
      fifo[2].push_back(16'h0332);
      fifo[3].push_back(16'h0043);
      fifo[0].push_back(16'h0314);
      pop_order.delete();
      pop_cycles.delete();
      wait_idle();
      check("rr_count", 64'(pop_order.size()), 64'd5);
      for (int i = 0; i < 5 && i < pop_order.size(); i++)
         check("rr_order", 64'(pop_order[i]), 64'(rr_exp[i]));
      for (int i = 1; i < 5 && i < pop_cycles.size(); i++)
         check("rr_spacing", 64'(pop_cycles[i] - pop_cycles[i-1]), 64'd3);
      check("rr_pkt", {48'd0, pkt_cnt}, 64'(exp_pkt));

      // Single packet from device 1 to device 2.
      pop_order.delete();
      fifo[1].push_back(16'h02AB);
      wait_idle();
      check("single_grant", 64'(pop_order.size() > 0 ? pop_order[0] : -1), 64'd1);
      check("single_pkt", {48'd0, pkt_cnt}, 64'(exp_pkt));

      // Broadcast from device 2.
      fifo[2].push_back(16'hFF55);
      wait_idle();
      check("bcast_pkt", {48'd0, pkt_cnt}, 64'(exp_pkt));

      // Out-of-range and self-addressed packets from device 0.
      pkt_before = exp_pkt;
      fifo[0].push_back(16'h0711);
      fifo[0].push_back(16'h0022);
      wait_idle();
      check("drop_cnt", {48'd0, drop_cnt}, 64'd2);
      check("drop_pkt_same", {48'd0, pkt_cnt}, 64'(pkt_before));

      // Reset asserted during ROUTE.
      fifo[1].push_back(16'h0312);
      n = 0;
      while (n < 20 && push_q.size() == 0) begin
         step();
         n++;
      end
      if (n >= 20) check("mid_pop_timeout", 64'd1, 64'd0);
      step();
      check("mid_busy", {63'd0, busy}, 64'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("mid_push", {60'd0, push}, 64'd0);
      check("mid_busy_rst", {63'd0, busy}, 64'd0);
      check("mid_pkt", {48'd0, pkt_cnt}, 64'd0);
      check("mid_drop", {48'd0, drop_cnt}, 64'd0);
      check("mid_pkt_s", {60'd0, pkt_s}, 64'd0);
      pop_order.delete();
      fifo[2].push_back(16'h0055);
      fifo[0].push_back(16'h0166);
      wait_idle();
      check("post_rst_grant", 64'(pop_order.size() > 0 ? pop_order[0] : -1), 64'd0);

      // 17 valid packets: wide counter keeps counting, 4-bit counter sticks at F.
      for (int i = 0; i < 17; i++) fifo[1].push_back(16'h0200 + 16'(i));
      wait_idle();
      check("sat_wide", {48'd0, pkt_cnt}, 64'(exp_pkt));
      check("sat_wide_lit", {48'd0, pkt_cnt}, 64'd19);
      check("sat_pkt", {60'd0, pkt_s}, 64'hF);
      check("sat_drop", {60'd0, drop_s}, 64'(exp_drop));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
